// File: rtl/fryer_ctrl.sv
// Air fryer cooking sequencer: setpoint entry, cook countdown and done buzzer,
// with heater hysteresis control and fan/buzzer drive. All outputs registered.
module fryer_ctrl #(
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned TEMP_MIN  = 80,
    parameter int unsigned TEMP_MAX  = 200,
    parameter int unsigned TEMP_STEP = 10,
    parameter int unsigned TEMP_DEF  = 180,
    parameter int unsigned TIME_DEF  = 15,
    parameter int unsigned HYST      = 5,
    parameter int unsigned BUZZ_S    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  key_pulse,
    input  logic [7:0]  temp_meas,
    output logic [1:0]  state,
    output logic [7:0]  temp_set,
    output logic [5:0]  time_set,
    output logic [11:0] remain_s,
    output logic        heater_on,
    output logic        fan_on,
    output logic        buzzer
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BW = (BUZZ_S > 1) ? $clog2(BUZZ_S + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LAST  = BW'(BUZZ_S - 1);

    localparam logic [8:0] T_MIN9  = 9'(TEMP_MIN);
    localparam logic [8:0] T_MAX9  = 9'(TEMP_MAX);
    localparam logic [8:0] T_STEP9 = 9'(TEMP_STEP);
    localparam logic [8:0] HYST9   = 9'(HYST);
    localparam logic [5:0] TIME_MIN = 6'd1;
    localparam logic [5:0] TIME_MAX = 6'd60;

    logic k_start, k_stop, k_tup, k_tdn, k_mup, k_mdn;

    assign k_start = key_pulse[0];
    assign k_stop  = key_pulse[1];
    assign k_tup   = key_pulse[2];
    assign k_tdn   = key_pulse[3];
    assign k_mup   = key_pulse[4];
    assign k_mdn   = key_pulse[5];

    logic [PW-1:0] presc, presc_nx, presc_run;
    logic [BW-1:0] buzz_cnt, buzz_cnt_nx;
    logic [1:0]    state_nx;
    logic [11:0]   remain_nx;
    logic [7:0]    temp_set_nx, temp_adj;
    logic [5:0]    time_set_nx, time_adj;
    logic          heater_nx;
    logic          tick;
    logic          to_idle;
    logic [8:0]    temp_up9;
    logic [8:0]    heat_lo9;

    assign tick      = (presc == PRESC_LAST);
    assign presc_run = tick ? '0 : presc + 1'b1;
    assign temp_up9  = {1'b0, temp_set} + T_STEP9;
    assign heat_lo9  = {1'b0, temp_set} - HYST9;

    // Saturating setpoint adjustment; opposing keys in the same cycle cancel.
    always_comb begin
        temp_adj = temp_set;
        if (k_tup && !k_tdn) begin
            temp_adj = (temp_up9 > T_MAX9) ? T_MAX9[7:0] : temp_up9[7:0];
        end else if (k_tdn && !k_tup) begin
            temp_adj = ({1'b0, temp_set} < T_MIN9 + T_STEP9) ? T_MIN9[7:0]
                                                             : temp_set - T_STEP9[7:0];
        end

        time_adj = time_set;
        if (k_mup && !k_mdn) begin
            time_adj = (time_set >= TIME_MAX) ? TIME_MAX : time_set + 6'd1;
        end else if (k_mdn && !k_mup) begin
            time_adj = (time_set <= TIME_MIN) ? TIME_MIN : time_set - 6'd1;
        end
    end

    always_comb begin
        state_nx    = state;
        presc_nx    = presc;
        remain_nx   = remain_s;
        buzz_cnt_nx = buzz_cnt;
        temp_set_nx = temp_set;
        time_set_nx = time_set;
        to_idle     = 1'b0;

        case (state)
            S_IDLE: begin
                if (k_stop) begin
                    to_idle = 1'b1;
                end else if (k_start) begin
                    state_nx  = S_RUN;
                    presc_nx  = '0;
                    remain_nx = 12'(time_set) * 12'd60;
                end else begin
                    temp_set_nx = temp_adj;
                    time_set_nx = time_adj;
                end
            end
            S_RUN: begin
                if (k_stop) begin
                    to_idle = 1'b1;
                end else if (k_start) begin
                    state_nx = S_PAUSE;
                end else begin
                    presc_nx = presc_run;
                    if (tick) begin
                        if (remain_s <= 12'd1) begin
                            state_nx    = S_DONE;
                            remain_nx   = '0;
                            presc_nx    = '0;
                            buzz_cnt_nx = '0;
                        end else begin
                            remain_nx = remain_s - 12'd1;
                        end
                    end
                end
            end
            S_PAUSE: begin
                // Prescaler phase is kept so the resumed second is not shortened.
                if (k_stop) begin
                    to_idle = 1'b1;
                end else if (k_start) begin
                    state_nx = S_RUN;
                end
            end
            default: begin
                if (k_stop || k_start) begin
                    to_idle = 1'b1;
                end else begin
                    presc_nx = presc_run;
                    if (tick) begin
                        if (buzz_cnt >= BUZZ_LAST) begin
                            to_idle = 1'b1;
                        end else begin
                            buzz_cnt_nx = buzz_cnt + 1'b1;
                        end
                    end
                end
            end
        endcase

        if (to_idle) begin
            state_nx    = S_IDLE;
            remain_nx   = '0;
            presc_nx    = '0;
            buzz_cnt_nx = '0;
        end
    end

    // Heater follows the next state so it drops in the same edge RUN is left.
    always_comb begin
        heater_nx = 1'b0;
        if (state_nx == S_RUN) begin
            if ({1'b0, temp_meas} < heat_lo9) begin
                heater_nx = 1'b1;
            end else if (temp_meas >= temp_set) begin
                heater_nx = 1'b0;
            end else begin
                heater_nx = heater_on;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            temp_set  <= 8'(TEMP_DEF);
            time_set  <= 6'(TIME_DEF);
            remain_s  <= '0;
            presc     <= '0;
            buzz_cnt  <= '0;
            heater_on <= 1'b0;
            fan_on    <= 1'b0;
            buzzer    <= 1'b0;
        end else begin
            state     <= state_nx;
            temp_set  <= temp_set_nx;
            time_set  <= time_set_nx;
            remain_s  <= remain_nx;
            presc     <= presc_nx;
            buzz_cnt  <= buzz_cnt_nx;
            heater_on <= heater_nx;
            fan_on    <= (state_nx == S_RUN) || (state_nx == S_PAUSE);
            buzzer    <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_fryer_ctrl.sv
// Directed bench for fryer_ctrl: setpoint vector table, then hand-written
// countdown, pause, heater hysteresis, DONE and async reset sequences.
module tb_fryer_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  key_pulse;
    logic [7:0]  temp_meas;
    logic [1:0]  state;
    logic [7:0]  temp_set;
    logic [5:0]  time_set;
    logic [11:0] remain_s;
    logic        heater_on;
    logic        fan_on;
    logic        buzzer;

    int checks   = 0;
    int failures = 0;

    fryer_ctrl #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .temp_meas (temp_meas),
        .state     (state),
        .temp_set  (temp_set),
        .time_set  (time_set),
        .remain_s  (remain_s),
        .heater_on (heater_on),
        .fan_on    (fan_on),
        .buzzer    (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] keys;
        logic [7:0] exp_temp;
        logic [5:0] exp_time;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [5:0] k);
        key_pulse = k;
        @(negedge clk);
        key_pulse = '0;
    endtask

    initial begin
        int n;
        int m;

        rst       = 1'b1;
        key_pulse = '0;
        temp_meas = 8'd25;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_state",  state, 0);
        check("rst_temp",   temp_set, 180);
        check("rst_time",   time_set, 15);
        check("rst_remain", remain_s, 0);
        check("rst_heater", heater_on, 0);
        check("rst_fan",    fan_on, 0);
        check("rst_buzzer", buzzer, 0);

        vecs[0] = '{6'h04, 8'd190, 6'd15};
        vecs[1] = '{6'h04, 8'd200, 6'd15};
        vecs[2] = '{6'h04, 8'd200, 6'd15};
        vecs[3] = '{6'h0C, 8'd200, 6'd15};
        vecs[4] = '{6'h08, 8'd190, 6'd15};
        vecs[5] = '{6'h14, 8'd200, 6'd16};
        vecs[6] = '{6'h30, 8'd200, 6'd16};
        vecs[7] = '{6'h06, 8'd200, 6'd16};
        vecs[8] = '{6'h28, 8'd190, 6'd15};

        for (int i = 0; i < 9; i++) begin
            pulse(vecs[i].keys);
            check($sformatf("vec%0d_temp", i), temp_set, vecs[i].exp_temp);
            check($sformatf("vec%0d_time", i), time_set, vecs[i].exp_time);
            check($sformatf("vec%0d_state", i), state, 0);
        end

        for (int i = 0; i < 20; i++) pulse(6'h08);
        check("temp_floor", temp_set, 80);
        for (int i = 0; i < 10; i++) pulse(6'h04);
        check("temp_back_180", temp_set, 180);
        for (int i = 0; i < 20; i++) pulse(6'h20);
        check("time_floor", time_set, 1);

        // Full cook: 60 s at 4 cycles per tick, then 3-tick buzz.
        pulse(6'h01);
        check("start_state",  state, 1);
        check("start_remain", remain_s, 60);
        check("start_fan",    fan_on, 1);
        repeat (3) @(negedge clk);
        check("pre_tick_remain", remain_s, 60);
        @(negedge clk);
        check("first_tick_remain", remain_s, 59);
        n = 4;
        while (state != 2'b11 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_latency", n, 240);
        check("done_buzzer", buzzer, 1);
        check("done_remain", remain_s, 0);
        check("done_fan",    fan_on, 0);
        m = 0;
        while (state == 2'b11 && m < 50) begin
            @(negedge clk);
            m++;
        end
        check("buzz_cycles", m, 12);
        check("post_buzz_state",  state, 0);
        check("post_buzz_buzzer", buzzer, 0);

        // Pause at remain 50 with prescaler mid-phase (2), resume without loss.
        pulse(6'h01);
        repeat (42) @(negedge clk);
        check("pre_pause_remain", remain_s, 50);
        pulse(6'h01);
        check("pause_state",  state, 2);
        check("pause_remain", remain_s, 50);
        repeat (100) @(negedge clk);
        check("pause_hold_remain", remain_s, 50);
        check("pause_hold_state",  state, 2);
        check("pause_fan",         fan_on, 1);
        pulse(6'h01);
        check("resume_state",  state, 1);
        check("resume_remain", remain_s, 50);
        @(negedge clk);
        check("resume_phase3", remain_s, 50);
        @(negedge clk);
        check("resume_tick", remain_s, 49);

        pulse(6'h03);
        check("startstop_state",  state, 0);
        check("startstop_remain", remain_s, 0);
        check("startstop_fan",    fan_on, 0);

        // Heater hysteresis around setpoint 180 (band 175..180).
        temp_meas = 8'd170;
        pulse(6'h01);
        check("heat_170", heater_on, 1);
        temp_meas = 8'd178; @(negedge clk); check("heat_178", heater_on, 1);
        temp_meas = 8'd175; @(negedge clk); check("heat_175", heater_on, 1);
        temp_meas = 8'd180; @(negedge clk); check("heat_180", heater_on, 0);
        temp_meas = 8'd176; @(negedge clk); check("heat_176", heater_on, 0);
        temp_meas = 8'd174; @(negedge clk); check("heat_174", heater_on, 1);
        pulse(6'h01);
        check("heat_pause_off", heater_on, 0);
        pulse(6'h01);
        check("heat_resume_on", heater_on, 1);

        n = 0;
        while (state != 2'b11 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("reach_done", state, 3);
        check("done_heater_off", heater_on, 0);
        pulse(6'h01);
        check("done_start_idle",  state, 0);
        check("done_start_buzz",  buzzer, 0);

        // Asynchronous reset in the middle of a 300 s cook.
        for (int i = 0; i < 4; i++) pulse(6'h10);
        pulse(6'h04);
        check("pre_rst_time", time_set, 5);
        check("pre_rst_temp", temp_set, 190);
        temp_meas = 8'd100;
        pulse(6'h01);
        check("cook300_remain", remain_s, 300);
        @(negedge clk);
        check("cook300_heater", heater_on, 1);
        #2 rst = 1'b1;
        #1;
        check("async_state",  state, 0);
        check("async_remain", remain_s, 0);
        check("async_heater", heater_on, 0);
        check("async_fan",    fan_on, 0);
        check("async_buzzer", buzzer, 0);
        check("async_temp",   temp_set, 180);
        check("async_time",   time_set, 15);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_state", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
